// File: rtl/output_channel_sequencer.sv
// Output channel sequencer: picks one truncated filter channel for the output port.
// It supports fixed-select, round-robin scan with a per-channel dwell, and hold.
//
// mode       | meaning
// MODE_FIXED | output follows the select input; o_valid echoes the sample strobe
// MODE_SCAN  | round-robin over channels, dwell samples per channel
// MODE_HOLD  | outputs and scan state frozen, no strobes
// MODE_RSVD  | behaves as MODE_FIXED
module output_channel_sequencer #(
    parameter int NUM_FILTERS    = 8,
    parameter int SUM_TRUNCATION = 8,
    parameter int SEL_WIDTH      = 8,
    parameter int DWELL_WIDTH    = 8,
    localparam int CH_W          = $clog2(NUM_FILTERS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_FILTERS*SUM_TRUNCATION-1:0] i_truncated_wavelet_out,
    input  logic                                  i_sample_valid,
    input  logic [1:0]                            i_mode,
    input  logic [SEL_WIDTH-1:0]                  i_select_output_channel,
    input  logic [DWELL_WIDTH-1:0]                i_dwell,
    output logic [SUM_TRUNCATION-1:0]             o_multiplexed_wavelet_out,
    output logic [CH_W-1:0]                       o_channel,
    output logic                                  o_valid,
    output logic                                  o_frame_start
);

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_SCAN  = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    mode_t                   mode_q, mode_in;
    logic [CH_W-1:0]         scan_ch, scan_ch_nxt;
    logic [DWELL_WIDTH-1:0]  dwell_cnt, dwell_cnt_nxt;
    logic [SUM_TRUNCATION-1:0] data_nxt;
    logic [CH_W-1:0]         channel_nxt;
    logic                    valid_nxt, frame_nxt;

    logic                    restart;
    logic [CH_W-1:0]         cur_ch, fix_ch, mux_ch;
    logic [DWELL_WIDTH-1:0]  cur_cnt;
    logic [DWELL_WIDTH:0]    cnt_inc, dwell_eff;
    logic [SUM_TRUNCATION-1:0] mux_data;

    assign mode_in = mode_t'(i_mode);

    // Entering scan from fixed/reserved restarts in the same cycle; resuming from hold does not.
    assign restart   = (mode_in == MODE_SCAN) && (mode_q != MODE_SCAN) && (mode_q != MODE_HOLD);
    assign cur_ch    = restart ? '0 : scan_ch;
    assign cur_cnt   = restart ? '0 : dwell_cnt;
    assign cnt_inc   = {1'b0, cur_cnt} + 1'b1;
    assign dwell_eff = (i_dwell == '0) ? (DWELL_WIDTH+1)'(1) : {1'b0, i_dwell};

    assign fix_ch   = (32'(i_select_output_channel) < NUM_FILTERS) ? CH_W'(i_select_output_channel) : '0;
    assign mux_ch   = (mode_in == MODE_SCAN) ? cur_ch : fix_ch;
    assign mux_data = i_truncated_wavelet_out[mux_ch*SUM_TRUNCATION +: SUM_TRUNCATION];

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q                    <= MODE_FIXED;
            scan_ch                   <= '0;
            dwell_cnt                 <= '0;
            o_multiplexed_wavelet_out <= '0;
            o_channel                 <= '0;
            o_valid                   <= 1'b0;
            o_frame_start             <= 1'b0;
        end else begin
            mode_q                    <= mode_in;
            scan_ch                   <= scan_ch_nxt;
            dwell_cnt                 <= dwell_cnt_nxt;
            o_multiplexed_wavelet_out <= data_nxt;
            o_channel                 <= channel_nxt;
            o_valid                   <= valid_nxt;
            o_frame_start             <= frame_nxt;
        end
    end

    always_comb begin
        scan_ch_nxt   = scan_ch;
        dwell_cnt_nxt = dwell_cnt;
        data_nxt      = o_multiplexed_wavelet_out;
        channel_nxt   = o_channel;
        valid_nxt     = 1'b0;
        frame_nxt     = 1'b0;
        case (mode_in)
            MODE_SCAN: begin
                scan_ch_nxt   = cur_ch;
                dwell_cnt_nxt = cur_cnt;
                if (i_sample_valid) begin
                    data_nxt    = mux_data;
                    channel_nxt = cur_ch;
                    valid_nxt   = 1'b1;
                    frame_nxt   = (cur_ch == '0) && (cur_cnt == '0);
                    // >= so a dwell shrunk below the running count advances immediately
                    if (cnt_inc >= dwell_eff) begin
                        dwell_cnt_nxt = '0;
                        scan_ch_nxt   = (cur_ch == CH_W'(NUM_FILTERS-1)) ? '0 : cur_ch + 1'b1;
                    end else begin
                        dwell_cnt_nxt = cur_cnt + 1'b1;
                    end
                end
            end
            MODE_HOLD: begin
            end
            default: begin
                data_nxt    = mux_data;
                channel_nxt = fix_ch;
                valid_nxt   = i_sample_valid;
            end
        endcase
    end

endmodule

// File: tb/tb_output_channel_sequencer.sv
// Scoreboard bench for output_channel_sequencer: stimulus pushes expected words,
// a negedge monitor pops and compares on every o_valid.
module tb_output_channel_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] wav;
    logic        i_sample_valid;
    logic [1:0]  i_mode;
    logic [7:0]  i_select_output_channel;
    logic [7:0]  i_dwell;
    logic [7:0]  o_data;
    logic [2:0]  o_channel;
    logic        o_valid;
    logic        o_frame_start;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] ch;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    output_channel_sequencer #(
        .NUM_FILTERS(8), .SUM_TRUNCATION(8), .SEL_WIDTH(8), .DWELL_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_truncated_wavelet_out(wav),
        .i_sample_valid(i_sample_valid),
        .i_mode(i_mode),
        .i_select_output_channel(i_select_output_channel),
        .i_dwell(i_dwell),
        .o_multiplexed_wavelet_out(o_data),
        .o_channel(o_channel),
        .o_valid(o_valid),
        .o_frame_start(o_frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got data 0x%0h ch %0d, expected no strobe", o_data, o_channel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data", int'(o_data), int'(e.d));
                chk("sb_channel", int'(o_channel), int'(e.ch));
                chk("sb_frame_start", int'(o_frame_start), int'(e.fs));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int k = 0; k < 8; k++) wav[k*8 +: 8] = 8'(base + 8'(k));
    endtask

    task automatic expect_word(input logic [7:0] d, input logic [2:0] ch, input logic fs);
        exp_t e;
        e.d = d; e.ch = ch; e.fs = fs;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input bit push, input logic [7:0] d, input logic [2:0] ch, input logic fs);
        if (push) expect_word(d, ch, fs);
        i_sample_valid = 1'b1;
        step();
        i_sample_valid = 1'b0;
    endtask

    task automatic restart_scan(input logic [7:0] dwell);
        i_mode = 2'b00;
        step();
        i_dwell = dwell;
        i_mode  = 2'b01;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_sample_valid = 1'b0;
        i_mode = 2'b00;
        i_select_output_channel = 8'd3;
        i_dwell = 8'd2;
        set_data(8'h10);
        step(3);

        @(negedge clk);
        chk("reset_data", int'(o_data), 0);
        chk("reset_channel", int'(o_channel), 0);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_frame", int'(o_frame_start), 0);
        step();
        rst = 1'b0;

        // Test 1: fixed select 3
        step(2);
        pulse(1, 8'h13, 3'd3, 1'b0);
        step(2);
        // data reloads every clk even without a strobe
        i_select_output_channel = 8'd5;
        step(2);
        @(negedge clk);
        chk("fixed_ungated_data", int'(o_data), 'h15);
        chk("fixed_ungated_ch", int'(o_channel), 5);

        // Test 2: out-of-range select maps to ch 0
        step();
        i_select_output_channel = 8'd200;
        step(2);
        @(negedge clk);
        chk("fixed_oor_data", int'(o_data), 'h10);
        chk("fixed_oor_ch", int'(o_channel), 0);
        chk("fixed_oor_novalid", int'(o_valid), 0);
        step();
        pulse(1, 8'h10, 3'd0, 1'b0);
        step(2);

        // Test 3: scan, dwell 2, 17 samples
        i_dwell = 8'd2;
        i_mode  = 2'b01;
        step(2);
        for (int i = 0; i < 17; i++) begin
            logic [2:0] ch;
            ch = 3'((i / 2) % 8);
            pulse(1, 8'(8'h10 + 8'(ch)), ch, (i % 2 == 0) && (ch == 3'd0));
            step();
        end
        step(2);

        // Test 4: scan, dwell 0 acts as 1; restart coincident with the first strobe
        restart_scan(8'd0);
        for (int i = 0; i < 9; i++) begin
            logic [2:0] ch;
            ch = 3'(i % 8);
            pulse(1, 8'(8'h10 + 8'(ch)), ch, ch == 3'd0);
            step();
            if (i == 3) begin
                @(negedge clk);
                chk("gap_hold_data", int'(o_data), 'h13);
                chk("gap_hold_ch", int'(o_channel), 3);
                chk("gap_novalid", int'(o_valid), 0);
            end
            step();
        end

        // Dwell shrunk below the running count advances on the next sample
        restart_scan(8'd3);
        pulse(1, 8'h10, 3'd0, 1'b1);
        pulse(1, 8'h10, 3'd0, 1'b0);
        i_dwell = 8'd1;
        pulse(1, 8'h10, 3'd0, 1'b0);
        pulse(1, 8'h11, 3'd1, 1'b0);
        step(2);

        // Test 5: scan to ch5, hold 10 clks with strobes, then resume
        restart_scan(8'd1);
        for (int i = 0; i < 5; i++) pulse(1, 8'(8'h10 + 8'(i)), 3'(i), i == 0);
        step(2);
        set_data(8'h40);
        i_mode = 2'b10;
        i_sample_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            chk("hold_data", int'(o_data), 'h14);
            chk("hold_ch", int'(o_channel), 4);
        end
        step();
        i_sample_valid = 1'b0;
        i_mode = 2'b01;
        pulse(1, 8'h45, 3'd5, 1'b0);
        step(2);

        // Test 6: reset mid-scan with a coincident strobe
        rst = 1'b1;
        i_sample_valid = 1'b1;
        step();
        i_sample_valid = 1'b0;
        @(negedge clk);
        chk("rst_scan_data", int'(o_data), 0);
        chk("rst_scan_ch", int'(o_channel), 0);
        chk("rst_scan_valid", int'(o_valid), 0);
        chk("rst_scan_frame", int'(o_frame_start), 0);
        step();
        rst = 1'b0;
        step();
        pulse(1, 8'h40, 3'd0, 1'b1);
        pulse(1, 8'h41, 3'd1, 1'b0);
        step(3);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
